// File: rtl/vector_scalar_expand_pkg.sv
// vector_scalar_expand_pkg: shared types and the scalar truncation helper for the expansion unit
package vector_scalar_expand_pkg;
  typedef enum logic [1:0] {EW8, EW16, EW32} vsew_e;
  typedef enum logic [1:0] {EXP_SPLAT, EXP_MERGE, EXP_MOVS} exp_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT, ST_DONE} exp_state_e;
  function automatic logic [31:0] sew_trunc(vsew_e s, logic [31:0] x);
    return s == EW8 ? {24'b0, x[7:0]} : s == EW16 ? {16'b0, x[15:0]} : x;
  endfunction
endpackage

// File: rtl/vector_elem_enable.sv
// vector_elem_enable: per-byte write enables of one register of a group (vsew, reg_idx, vl, op -> be)
module vector_elem_enable
  import vector_scalar_expand_pkg::*;
#(parameter int VLEN = 64) (
  input  vsew_e                  vsew,
  input  logic [2:0]             reg_idx,
  input  logic [$bits(VLEN)-1:0] vl,
  input  exp_op_e                op,
  output logic [VLEN/8-1:0]      be
);
  always_comb begin
    be = '0;
    for (int b = 0; b < VLEN/8; b++)
      be[b] = op == EXP_MOVS ? (reg_idx == 3'd0 && (b >> vsew) == 0 && vl != '0)
            : int'(reg_idx) * ((VLEN/8) >> vsew) + (b >> vsew) < vl;
  end
endmodule

// File: rtl/vector_scalar_expand.sv
// vector_scalar_expand: broadcasts a scalar across a vector register group, one VLEN beat per register
module vector_scalar_expand
  import vector_scalar_expand_pkg::*;
#(parameter int VLEN = 64) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  exp_op_e                op_i,
  input  vsew_e                  vsew_i,
  input  logic [3:0]             vlmul_regs_i,
  input  logic [$bits(VLEN)-1:0] vl_i,
  input  logic [31:0]            scalar_i,
  input  logic [VLEN-1:0]        mask_i,
  output logic [2:0]             rd_idx_o,
  input  logic [VLEN-1:0]        vs2_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [VLEN-1:0]        out_data_o,
  output logic [VLEN/8-1:0]      out_be_o,
  output logic [2:0]             out_reg_o,
  output logic                   out_last_o,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int MW = $clog2(VLEN);
  exp_state_e state, state_n;
  exp_op_e op_q;
  vsew_e sew_q;
  logic [3:0] nbeats_q, cnt;
  logic [$bits(VLEN)-1:0] vl_q;
  logic [31:0] scalar_q;
  logic [VLEN-1:0] splat, data_n;
  logic [VLEN/8-1:0] be_n;
  logic load, last_load, accept;
  vector_elem_enable #(.VLEN(VLEN)) u_en (.vsew(sew_q), .reg_idx(cnt[2:0]), .vl(vl_q), .op(op_q), .be(be_n));
  always_comb begin
    load = state == ST_RUN && (!out_valid_o || out_ready_i);
    last_load = load && cnt == nbeats_q - 4'd1;
    accept = out_valid_o && out_ready_i;
    splat = sew_q == EW8 ? {VLEN/8{scalar_q[7:0]}} : sew_q == EW16 ? {VLEN/16{scalar_q[15:0]}} : {VLEN/32{scalar_q}};
  end
  always_comb begin
    data_n = '0;
    for (int b = 0; b < VLEN/8; b++)
      data_n[8*b +: 8] = !be_n[b] ? 8'h0
        : op_q == EXP_MERGE && !mask_i[MW'(int'(cnt[2:0]) * ((VLEN/8) >> sew_q) + (b >> sew_q))] ? vs2_i[8*b +: 8]
        : splat[8*b +: 8];
  end
  always_ff @(posedge clk)
    if (reset) state <= ST_IDLE;
    else state <= state_n;
  always_comb
    state_n = state == ST_IDLE ? (start_i ? (vl_i == '0 ? ST_DONE : ST_RUN) : ST_IDLE)
            : state == ST_RUN  ? (last_load ? ST_WAIT : ST_RUN)
            : state == ST_WAIT ? (accept ? ST_DONE : ST_WAIT)
            : ST_IDLE;
  always_comb begin
    busy_o = state != ST_IDLE;
    rd_idx_o = state == ST_RUN ? cnt[2:0] : 3'd0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      op_q <= EXP_SPLAT;
      sew_q <= EW8;
      nbeats_q <= '0;
      vl_q <= '0;
      scalar_q <= '0;
      cnt <= '0;
      out_valid_o <= 1'b0;
      out_data_o <= '0;
      out_be_o <= '0;
      out_reg_o <= '0;
      out_last_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= state == ST_DONE;
      if (state == ST_IDLE && start_i) begin
        op_q <= op_i;
        sew_q <= vsew_i;
        nbeats_q <= op_i == EXP_MOVS ? 4'd1 : vlmul_regs_i;
        vl_q <= vl_i;
        scalar_q <= sew_trunc(vsew_i, scalar_i);
        cnt <= '0;
      end
      if (load) begin
        out_valid_o <= 1'b1;
        out_data_o <= data_n;
        out_be_o <= be_n;
        out_reg_o <= cnt[2:0];
        out_last_o <= last_load;
        cnt <= cnt + 4'd1;
      end else if (accept) out_valid_o <= 1'b0;
    end
endmodule

// File: tb/tb_vector_scalar_expand.sv
// tb_vector_scalar_expand: randomized and directed checks of the expansion unit against an element-level model
module tb_vector_scalar_expand;
  import vector_scalar_expand_pkg::*;
  typedef struct {
    logic [63:0] data;
    logic [7:0]  be;
    logic [2:0]  rg;
    logic        last;
  } beat_t;
  logic clk = 0, reset = 1, start_i = 0, out_ready_i = 1;
  exp_op_e op_i = EXP_SPLAT;
  vsew_e vsew_i = EW8;
  logic [3:0] vlmul_regs_i = 4'd1;
  logic [31:0] vl_i = 0, scalar_i = 0;
  logic [63:0] mask_i = 0, vs2_i, out_data_o;
  logic [2:0] rd_idx_o, out_reg_o;
  logic [7:0] out_be_o;
  logic out_valid_o, out_last_o, busy_o, done_o;
  logic [63:0] vs2_regs [8];
  beat_t expq[$], logq[$], hb, eb;
  int vectors = 0, miscompares = 0, cd = -1;
  bit mbusy = 0, held = 0, exp_done;
  vector_scalar_expand #(.VLEN(64)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .vsew_i(vsew_i),
    .vlmul_regs_i(vlmul_regs_i), .vl_i(vl_i), .scalar_i(scalar_i), .mask_i(mask_i),
    .rd_idx_o(rd_idx_o), .vs2_i(vs2_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_be_o(out_be_o), .out_reg_o(out_reg_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .done_o(done_o));
  always #5 clk = ~clk;
  assign vs2_i = vs2_regs[rd_idx_o];
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic void model(exp_op_e op, vsew_e sw, int lmul, int vl, logic [31:0] sc, logic [63:0] mk);
    int sew = 8 << int'(sw);
    int epr = 64 / sew;
    int nb = vl == 0 ? 0 : op == EXP_MOVS ? 1 : lmul;
    logic [63:0] em = (64'd1 << sew) - 64'd1;
    logic [63:0] s = {32'd0, sc} & em;
    for (int r = 0; r < nb; r++) begin
      beat_t b;
      b.data = 0;
      b.be = 0;
      b.rg = 3'(r);
      b.last = r == nb - 1;
      for (int i = 0; i < epr; i++) begin
        int e = r * epr + i;
        bit en = op == EXP_MOVS ? e == 0 : e < vl;
        logic [63:0] v = (op == EXP_MERGE && !mk[e]) ? (vs2_regs[r] >> (i * sew)) & em : s;
        if (en) begin
          b.data |= v << (i * sew);
          b.be |= 8'(((1 << (sew / 8)) - 1) << (i * sew / 8));
        end
      end
      expq.push_back(b);
    end
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      cd = -1;
      mbusy = 0;
      held = 0;
    end else begin
      exp_done = cd == 0;
      if (exp_done) mbusy = 0;
      check("done", done_o, exp_done);
      check("busy", busy_o, mbusy);
      if (cd >= 0) cd--;
      if (held) begin
        check("hold_valid", out_valid_o, 1);
        check("hold_data", out_data_o, hb.data);
        check("hold_be", out_be_o, hb.be);
        check("hold_reg", out_reg_o, hb.rg);
        check("hold_last", out_last_o, hb.last);
      end
      held = 0;
      if (out_valid_o) begin
        if (!out_ready_i) begin
          held = 1;
          hb = '{out_data_o, out_be_o, out_reg_o, out_last_o};
        end else if (expq.size() == 0) check("spurious_valid", out_valid_o, 0);
        else begin
          eb = expq.pop_front();
          check("beat_data", out_data_o, eb.data);
          check("beat_be", out_be_o, eb.be);
          check("beat_reg", out_reg_o, eb.rg);
          check("beat_last", out_last_o, eb.last);
          logq.push_back('{out_data_o, out_be_o, out_reg_o, out_last_o});
          if (eb.last) cd = 1;
        end
      end
      if (start_i && !mbusy) begin
        mbusy = 1;
        model(op_i, vsew_i, int'(vlmul_regs_i), int'(vl_i), scalar_i, mask_i);
        if (vl_i == 0) cd = 1;
      end
    end
  end
  task automatic run_op(exp_op_e op, vsew_e sw, int lmul, int vl, logic [31:0] sc, int mode, int rst_at,
                        output int cyc, output int fv);
    int stalls = 0;
    cyc = 0;
    fv = -1;
    logq.delete();
    op_i = op;
    vsew_i = sw;
    vlmul_regs_i = 4'(lmul);
    vl_i = vl;
    scalar_i = sc;
    start_i = 1;
    out_ready_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    while (!done_o && cyc < 300) begin
      if (out_valid_o && fv < 0) fv = cyc;
      if (rst_at >= 0 && out_valid_o && out_reg_o == 3'(rst_at)) begin
        reset = 1;
        @(posedge clk); #1;
        check("rst_valid", out_valid_o, 0);
        check("rst_data", out_data_o, 0);
        check("rst_be", out_be_o, 0);
        check("rst_reg", out_reg_o, 0);
        check("rst_last", out_last_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_rd_idx", rd_idx_o, 0);
        reset = 0;
        out_ready_i = 1;
        return;
      end
      if (mode == 2 && out_valid_o && out_reg_o == 3'd1 && stalls < 3) begin
        out_ready_i = 0;
        stalls++;
      end else out_ready_i = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check("op_completes", done_o, 1);
    check("queue_drained", expq.size(), 0);
    out_ready_i = 1;
    @(posedge clk); #1;
  endtask
  initial begin
    int cyc, fv;
    for (int r = 0; r < 8; r++) vs2_regs[r] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", out_valid_o, 0);
    check("reset_data", out_data_o, 0);
    check("reset_be", out_be_o, 0);
    check("reset_reg", out_reg_o, 0);
    check("reset_last", out_last_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_rd_idx", rd_idx_o, 0);
    reset = 0;
    @(posedge clk); #1;
    run_op(EXP_SPLAT, EW8, 1, 5, 32'h1A5, 0, -1, cyc, fv);
    check("t1_beats", logq.size(), 1);
    check("t1_first_valid_cycle", fv, 1);
    if (logq.size() >= 1) begin
      check("t1_data", logq[0].data, 64'h000000A5A5A5A5A5);
      check("t1_be", logq[0].be, 8'h1F);
      check("t1_last", logq[0].last, 1);
    end
    mask_i = 64'b101010;
    for (int r = 0; r < 8; r++) vs2_regs[r] = 64'h1111111111111111;
    run_op(EXP_MERGE, EW16, 2, 6, 32'h0000BEEF, 0, -1, cyc, fv);
    check("t2_beats", logq.size(), 2);
    if (logq.size() >= 2) begin
      check("t2_b0_data", logq[0].data, 64'hBEEF1111BEEF1111);
      check("t2_b0_be", logq[0].be, 8'hFF);
      check("t2_b1_data", logq[1].data, 64'h00000000BEEF1111);
      check("t2_b1_be", logq[1].be, 8'h0F);
      check("t2_b1_last", logq[1].last, 1);
    end
    run_op(EXP_MOVS, EW32, 4, 8, 32'hCAFEF00D, 0, -1, cyc, fv);
    check("t3_beats", logq.size(), 1);
    if (logq.size() >= 1) begin
      check("t3_data", logq[0].data, 64'h00000000CAFEF00D);
      check("t3_be", logq[0].be, 8'h0F);
      check("t3_last", logq[0].last, 1);
    end
    run_op(EXP_SPLAT, EW8, 8, 0, 32'h55, 0, -1, cyc, fv);
    check("t4_beats", logq.size(), 0);
    check("t4_done_cycle", cyc, 1);
    check("t4_busy_after", busy_o, 0);
    run_op(EXP_SPLAT, EW16, 4, 16, 32'h12345678, 2, -1, cyc, fv);
    check("t5_beats", logq.size(), 4);
    for (int r = 0; r < 4; r++)
      if (r < logq.size()) check("t5_order", logq[r].rg, 3'(r));
    run_op(EXP_SPLAT, EW8, 8, 64, 32'h3C, 0, 2, cyc, fv);
    @(posedge clk); #1;
    run_op(EXP_SPLAT, EW32, 8, 16, 32'h89ABCDEF, 0, -1, cyc, fv);
    check("t6_restart_beats", logq.size(), 8);
    for (int n = 0; n < 40; n++) begin
      exp_op_e op = exp_op_e'($urandom_range(0, 2));
      vsew_e sw = vsew_e'($urandom_range(0, 2));
      int lmul = $urandom_range(1, 8);
      int vl = $urandom_range(0, lmul * (8 >> int'(sw)));
      mask_i = {$urandom, $urandom};
      for (int r = 0; r < 8; r++) vs2_regs[r] = {$urandom, $urandom};
      run_op(op, sw, lmul, vl, $urandom, 1, -1, cyc, fv);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
